// File: rtl/return_stream_packer_pkg.sv
// Shared parameters for the DDR return path (stream packer and return buffer).
// Stream words are 8 features wide; a return patch is 4096 bytes of stream words.
// Patch counts are carried as 16-bit values toward the return buffer.
package return_stream_packer_pkg;

  localparam int FEATURE_WIDTH        = 16;
  localparam int MEM_ADDR_WIDTH       = 32;
  localparam int CNT_WIDTH            = 24;
  localparam int RETURN_PATCH_BYTES   = 4096;
  localparam int WORDS_PER_PATCH_LOG2 = 8;
  localparam int PATCH_NUM_WIDTH      = 16;

endpackage

// File: rtl/return_stream_packer.sv
// Purpose: drives the DDR return buffer for one output task, forwards result words, zero-pads the last patch.
// Latency: zero-cycle pass-through of in_data to return_data while streaming; refresh/req take 2 cycles after start.
// Backpressure: return_buffer_ready low stalls both streaming and padding; in_ready follows return_buffer_ready.
module return_stream_packer #(
  parameter int FEATURE_WIDTH        = return_stream_packer_pkg::FEATURE_WIDTH,
  parameter int MEM_ADDR_WIDTH       = return_stream_packer_pkg::MEM_ADDR_WIDTH,
  parameter int CNT_WIDTH            = return_stream_packer_pkg::CNT_WIDTH,
  parameter int WORDS_PER_PATCH_LOG2 = return_stream_packer_pkg::WORDS_PER_PATCH_LOG2
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       task_start,
  input  logic [MEM_ADDR_WIDTH-1:0]  task_addr,
  input  logic [CNT_WIDTH-1:0]       task_words,
  output logic                       task_busy,
  output logic                       task_done,
  output logic                       task_err,
  input  logic [FEATURE_WIDTH*8-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [MEM_ADDR_WIDTH-1:0]  return_addr,
  output logic                       refresh_return_addr,
  output logic                       return_req,
  output logic [15:0]                return_patch_num,
  output logic [FEATURE_WIDTH*8-1:0] return_data,
  output logic                       return_data_valid,
  input  logic                       return_buffer_ready,
  output logic                       output_buffer_done,
  input  logic                       return_finish
);

  import return_stream_packer_pkg::*;

  localparam int PW   = WORDS_PER_PATCH_LOG2;
  localparam int HI_W = CNT_WIDTH - PW;
  // Largest task whose patch count still fits the 16-bit patch number.
  localparam logic [CNT_WIDTH-1:0] MAX_TASK_WORDS = {{HI_W{1'b1}}, {PW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFRESH,
    S_REQ,
    S_STREAM,
    S_PAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH:0]   word_cnt;
  logic [CNT_WIDTH:0]   word_cnt_inc;
  logic [CNT_WIDTH-1:0] task_words_q;
  logic [HI_W:0]        patch_calc;
  logic                 push;
  logic                 start_ok;
  logic                 start_bad;

  assign start_ok     = (state == S_IDLE) && task_start && (task_words <= MAX_TASK_WORDS);
  assign start_bad    = (state == S_IDLE) && task_start && (task_words >  MAX_TASK_WORDS);
  assign word_cnt_inc = word_cnt + (CNT_WIDTH+1)'(1);
  // A partially filled last patch still costs a whole patch.
  assign patch_calc   = {1'b0, task_words[CNT_WIDTH-1:PW]} + {{HI_W{1'b0}}, |task_words[PW-1:0]};
  assign task_busy    = (state != S_IDLE);

  // State register; reset drops every decoded strobe immediately.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and all return-buffer strobes.
  always_comb begin
    state_nxt           = state;
    in_ready            = 1'b0;
    return_data         = '0;
    return_data_valid   = 1'b0;
    refresh_return_addr = 1'b0;
    return_req          = 1'b0;
    output_buffer_done  = 1'b0;
    task_done           = 1'b0;
    push                = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = (task_words == '0) ? S_DONE : S_REFRESH;
        end
      end
      S_REFRESH: begin
        refresh_return_addr = 1'b1;
        state_nxt           = S_REQ;
      end
      S_REQ: begin
        // The buffer clears its FIFO on this pulse, so nothing is pushed yet.
        return_req = 1'b1;
        state_nxt  = S_STREAM;
      end
      S_STREAM: begin
        in_ready          = return_buffer_ready;
        return_data       = in_data;
        return_data_valid = in_valid & return_buffer_ready;
        push              = return_data_valid;
        if (push && (word_cnt_inc == {1'b0, task_words_q})) begin
          state_nxt = (word_cnt_inc[PW-1:0] != '0) ? S_PAD : S_DRAIN;
        end
      end
      S_PAD: begin
        return_data_valid = return_buffer_ready;
        push              = return_buffer_ready;
        if (push && (word_cnt_inc[PW-1:0] == '0)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        output_buffer_done = 1'b1;
        if (return_finish) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        task_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Task context: latched only on an accepted start; a rejected start leaves it untouched.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      return_addr      <= '0;
      return_patch_num <= '0;
      task_words_q     <= '0;
      word_cnt         <= '0;
      task_err         <= 1'b0;
    end else begin
      task_err <= start_bad;
      if (start_ok) begin
        return_addr      <= task_addr;
        return_patch_num <= PATCH_NUM_WIDTH'(patch_calc);
        task_words_q     <= task_words;
        word_cnt         <= '0;
      end else if (push) begin
        word_cnt <= word_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_return_stream_packer.sv
// Bench for return_stream_packer: table of whole tasks checked against a queue model,
// plus hand-written sequences for ignored starts, reset during padding and the size limit.
// The model predicts the pushed stream as the accepted words followed by zeros to a patch boundary.
module tb_return_stream_packer;
  import return_stream_packer_pkg::*;

  localparam int W = FEATURE_WIDTH * 8;

  logic                      system_clk = 1'b0;
  logic                      rst_n;
  logic                      task_start;
  logic [MEM_ADDR_WIDTH-1:0] task_addr;
  logic [CNT_WIDTH-1:0]      task_words;
  logic                      task_busy;
  logic                      task_done;
  logic                      task_err;
  logic [W-1:0]              in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [MEM_ADDR_WIDTH-1:0] return_addr;
  logic                      refresh_return_addr;
  logic                      return_req;
  logic [15:0]               return_patch_num;
  logic [W-1:0]              return_data;
  logic                      return_data_valid;
  logic                      return_buffer_ready;
  logic                      output_buffer_done;
  logic                      return_finish;

  int n_checks = 0;
  int n_fail   = 0;

  return_stream_packer dut (
    .system_clk          (system_clk),
    .rst_n               (rst_n),
    .task_start          (task_start),
    .task_addr           (task_addr),
    .task_words          (task_words),
    .task_busy           (task_busy),
    .task_done           (task_done),
    .task_err            (task_err),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .return_addr         (return_addr),
    .refresh_return_addr (refresh_return_addr),
    .return_req          (return_req),
    .return_patch_num    (return_patch_num),
    .return_data         (return_data),
    .return_data_valid   (return_data_valid),
    .return_buffer_ready (return_buffer_ready),
    .output_buffer_done  (output_buffer_done),
    .return_finish       (return_finish)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    logic [CNT_WIDTH-1:0]      words;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    int                        mode;      // 0: always ready/valid, 1: ready toggles every 3 cycles, random valid
    int                        fin_dly;   // extra DRAIN cycles before return_finish
    logic                      exp_err;
    logic [15:0]               exp_patch;
    int                        exp_pushes;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_strobes"}, W'({task_busy, task_done, task_err, in_ready, refresh_return_addr,
                                 return_req, return_data_valid, output_buffer_done}), '0);
    check({tag, "_addr"}, W'(return_addr), '0);
    check({tag, "_patch"}, W'(return_patch_num), '0);
    check({tag, "_data"}, return_data, '0);
  endtask

  // Runs one complete task (or a rejected start) and checks it against the queue model.
  task automatic run_vec(input string tag, input vec_t v);
    logic [W-1:0] prod[$];
    logic [W-1:0] expq[$];
    logic [W-1:0] got[$];
    int n, padded, consumed, refresh_cnt, req_cnt, refresh_iter, req_iter;
    int done_cnt, done_iter, obd_cnt, bad_push, overlap, patch_bad, busy_bad;
    int pushes_at_obd, data_mis;
    bit vld;

    n = int'(v.words);
    @(posedge system_clk); #1;
    task_start          = 1'b1;
    task_words          = v.words;
    task_addr           = v.addr;
    in_valid            = 1'b0;
    return_buffer_ready = 1'b1;
    return_finish       = 1'b0;

    if (v.exp_err) begin
      @(posedge system_clk); #1;
      task_start = 1'b0;
      @(negedge system_clk);
      check({tag, "_err_pulse"}, W'(task_err), W'(1));
      check({tag, "_err_busy"}, W'(task_busy), '0);
      @(posedge system_clk); #1;
      @(negedge system_clk);
      check({tag, "_err_width"}, W'(task_err), '0);
      check({tag, "_err_busy2"}, W'(task_busy), '0);
      return;
    end

    padded = ((n + 255) / 256) * 256;
    for (int k = 0; k < n + 3; k++) prod.push_back(rand_word());
    for (int k = 0; k < n; k++) expq.push_back(prod[k]);
    while (expq.size() < padded) expq.push_back('0);

    consumed = 0; refresh_cnt = 0; req_cnt = 0; refresh_iter = -1; req_iter = -1;
    done_cnt = 0; done_iter = -1; obd_cnt = 0; bad_push = 0; overlap = 0;
    patch_bad = 0; busy_bad = 0; pushes_at_obd = -1;

    for (int i = 0; i < 6000 && done_cnt == 0; i++) begin
      @(posedge system_clk); #1;
      task_start = 1'b0;
      if (v.mode == 0) begin
        return_buffer_ready = 1'b1;
        vld = (prod.size() > 0);
      end else begin
        return_buffer_ready = ((i / 3) % 2) == 0;
        vld = (prod.size() > 0) && ($urandom_range(0, 1) == 1);
      end
      in_valid      = vld;
      in_data       = vld ? prod[0] : rand_word();
      return_finish = (obd_cnt > v.fin_dly);
      @(negedge system_clk);
      if (refresh_return_addr) begin
        if (refresh_cnt == 0) refresh_iter = i;
        refresh_cnt++;
      end
      if (return_req) begin
        if (req_cnt == 0) req_iter = i;
        req_cnt++;
      end
      if (in_valid && in_ready) begin
        void'(prod.pop_front());
        consumed++;
      end
      if (return_data_valid) begin
        if (!return_buffer_ready) bad_push++;
        if (refresh_return_addr || return_req) overlap++;
        got.push_back(return_data);
      end
      if (return_patch_num !== v.exp_patch) patch_bad++;
      if (!task_busy) busy_bad++;
      if (output_buffer_done) begin
        if (obd_cnt == 0) pushes_at_obd = got.size();
        obd_cnt++;
      end
      if (task_done) begin
        done_cnt++;
        done_iter = i;
      end
    end
    check({tag, "_done_seen"}, W'(done_cnt), W'(1));

    @(posedge system_clk); #1;
    return_finish = 1'b0;
    in_valid      = 1'b0;
    @(negedge system_clk);
    check({tag, "_busy_after"}, W'(task_busy), '0);
    check({tag, "_done_width"}, W'(task_done), '0);

    data_mis = 0;
    for (int k = 0; k < got.size() && k < expq.size(); k++)
      if (got[k] !== expq[k]) data_mis++;

    if (n > 0) begin
      check({tag, "_refresh_iter"}, W'(refresh_iter), W'(0));
      check({tag, "_req_iter"}, W'(req_iter), W'(1));
      check({tag, "_obd_cycles"}, W'(obd_cnt), W'(v.fin_dly + 2));
      check({tag, "_pushes_at_obd"}, W'(pushes_at_obd), W'(padded));
    end else begin
      check({tag, "_done_iter"}, W'(done_iter), W'(0));
      check({tag, "_obd_cycles"}, W'(obd_cnt), '0);
    end
    check({tag, "_refresh_cnt"}, W'(refresh_cnt), W'(n > 0 ? 1 : 0));
    check({tag, "_req_cnt"}, W'(req_cnt), W'(n > 0 ? 1 : 0));
    check({tag, "_pushes"}, W'(got.size()), W'(v.exp_pushes));
    check({tag, "_push_model"}, W'(got.size()), W'(padded));
    check({tag, "_data"}, W'(data_mis), '0);
    check({tag, "_consumed"}, W'(consumed), W'(n));
    check({tag, "_push_not_ready"}, W'(bad_push), '0);
    check({tag, "_push_in_setup"}, W'(overlap), '0);
    check({tag, "_patch_stable"}, W'(patch_bad), '0);
    check({tag, "_busy_held"}, W'(busy_bad), '0);
    check({tag, "_addr"}, W'(return_addr), W'(v.addr));
  endtask

  // Start during STREAM is ignored; reset during padding clears everything at once.
  task automatic ignore_then_reset_in_pad();
    bit seen;
    @(posedge system_clk); #1;
    task_start = 1'b1; task_words = 24'd300; task_addr = 32'h6000_0000;
    return_buffer_ready = 1'b1; in_valid = 1'b0; return_finish = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge system_clk); #1;
      task_start = 1'b0;
      @(negedge system_clk);
      if (in_ready) seen = 1;
    end
    check("ign_reach_stream", W'(seen), W'(1));

    @(posedge system_clk); #1;
    task_start = 1'b1; task_words = 24'hFFFF01; task_addr = 32'h6600_0000;
    in_valid = 1'b1; in_data = rand_word();
    @(posedge system_clk); #1;
    task_start = 1'b0; in_data = rand_word();
    @(negedge system_clk);
    check("ign_no_err", W'(task_err), '0);
    check("ign_patch", W'(return_patch_num), W'(2));
    check("ign_addr", W'(return_addr), W'(32'h6000_0000));
    check("ign_busy", W'(task_busy), W'(1));

    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge system_clk); #1;
      in_data = rand_word();
      @(negedge system_clk);
      if (return_data_valid && !in_ready) seen = 1;
    end
    check("pad_reached", W'(seen), W'(1));
    repeat (5) begin
      @(posedge system_clk); #1;
      in_data = rand_word();
    end
    @(negedge system_clk);
    check("pad_valid", W'(return_data_valid), W'(1));
    check("pad_zero", return_data, '0);
    check("pad_in_ready", W'(in_ready), '0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_pad");
    @(posedge system_clk); #1;
    in_valid = 1'b0;
    @(negedge system_clk);
    rst_n = 1'b1;
  endtask

  // Largest legal task is accepted with patch count 0xFFFF; cut short by reset.
  task automatic max_size_start();
    @(posedge system_clk); #1;
    task_start = 1'b1; task_words = 24'hFFFF00; task_addr = 32'h7000_0000;
    @(posedge system_clk); #1;
    task_start = 1'b0;
    @(negedge system_clk);
    check("max_no_err", W'(task_err), '0);
    check("max_busy", W'(task_busy), W'(1));
    check("max_patch", W'(return_patch_num), W'(16'hFFFF));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_max");
    @(negedge system_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t after;
    rst_n = 1'b0; task_start = 1'b0; task_addr = '0; task_words = '0;
    in_data = '0; in_valid = 1'b1; return_buffer_ready = 1'b1; return_finish = 1'b0;

    vt[0] = '{words: 24'd512,     addr: 32'h1000_0000, mode: 0, fin_dly: 4, exp_err: 1'b0, exp_patch: 16'd2, exp_pushes: 512};
    vt[1] = '{words: 24'd300,     addr: 32'h2000_0000, mode: 0, fin_dly: 3, exp_err: 1'b0, exp_patch: 16'd2, exp_pushes: 512};
    vt[2] = '{words: 24'd0,       addr: 32'h3000_0000, mode: 0, fin_dly: 0, exp_err: 1'b0, exp_patch: 16'd0, exp_pushes: 0};
    vt[3] = '{words: 24'd256,     addr: 32'h4000_1000, mode: 1, fin_dly: 6, exp_err: 1'b0, exp_patch: 16'd1, exp_pushes: 256};
    vt[4] = '{words: 24'hFFFF01,  addr: 32'h5000_0000, mode: 0, fin_dly: 0, exp_err: 1'b1, exp_patch: 16'd0, exp_pushes: 0};
    vt[5] = '{words: 24'd1,       addr: 32'h0000_2000, mode: 1, fin_dly: 2, exp_err: 1'b0, exp_patch: 16'd1, exp_pushes: 256};
    vt[6] = '{words: 24'd257,     addr: 32'h0012_3000, mode: 1, fin_dly: 0, exp_err: 1'b0, exp_patch: 16'd2, exp_pushes: 512};
    vt[7] = '{words: 24'hFFFFFF,  addr: 32'h5100_0000, mode: 0, fin_dly: 0, exp_err: 1'b1, exp_patch: 16'd0, exp_pushes: 0};

    #12;
    check_zero("reset");
    @(negedge system_clk);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_vec($sformatf("vec%0d", t), vt[t]);
    end

    ignore_then_reset_in_pad();
    after = '{words: 24'd256, addr: 32'h0800_0000, mode: 0, fin_dly: 1, exp_err: 1'b0, exp_patch: 16'd1, exp_pushes: 256};
    run_vec("after_reset", after);

    max_size_start();
    run_vec("after_max", vt[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
